// File: rtl/csdiv11_if.sv
// Request/result bundle for the csdiv11 restoring divider.
// The sticky signal exists only when CSDIV_STICKY_EN is defined.
interface csdiv11_if #(
  parameter int unsigned W = 11
);
  logic             in_valid;
  logic             in_ready;
  logic [2*W-1:0]   n;
  logic [W-1:0]     d;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     q;
  logic [W-1:0]     r;
  logic             dz;
  logic             ovf;
`ifdef CSDIV_STICKY_EN
  logic             sticky;

  modport master (
    output in_valid, n, d, out_ready,
    input  in_ready, out_valid, q, r, dz, ovf, sticky
  );

  modport slave (
    input  in_valid, n, d, out_ready,
    output in_ready, out_valid, q, r, dz, ovf, sticky
  );
`else
  modport master (
    output in_valid, n, d, out_ready,
    input  in_ready, out_valid, q, r, dz, ovf
  );

  modport slave (
    input  in_valid, n, d, out_ready,
    output in_ready, out_valid, q, r, dz, ovf
  );
`endif
endinterface

// File: rtl/csdiv11.sv
// Iterative unsigned restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per cycle.
// Optional inexact flag on the sticky port when CSDIV_STICKY_EN is defined.
module csdiv11 #(
  parameter int unsigned W = 11
) (
  input  logic      clk,
  input  logic      reset,
  csdiv11_if.slave  bus
);

  localparam int unsigned CntW = $clog2(W);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    lo_q, lo_d;
  logic [W-1:0]    dv_q, dv_d;
  logic [W-1:0]    qreg_q, qreg_d;
  logic [W-1:0]    q_q, q_d;
  logic [W-1:0]    r_q, r_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dz_q, dz_d;
  logic            ovf_q, ovf_d;
`ifdef CSDIV_STICKY_EN
  logic            sticky_q, sticky_d;
`endif

  logic [W:0]      shifted;
  logic [W:0]      diff;
  logic            qbit;
  logic [W-1:0]    rem_next;
  logic [W-1:0]    qreg_next;

  always_comb begin
    // rem < d always holds, so the difference fits in W bits and its MSB is the borrow.
    shifted   = {rem_q, lo_q[W-1]};
    diff      = shifted - {1'b0, dv_q};
    qbit      = ~diff[W];
    rem_next  = qbit ? diff[W-1:0] : shifted[W-1:0];
    qreg_next = {qreg_q[W-2:0], qbit};

    state_d  = state_q;
    rem_d    = rem_q;
    lo_d     = lo_q;
    dv_d     = dv_q;
    qreg_d   = qreg_q;
    q_d      = q_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
`ifdef CSDIV_STICKY_EN
    sticky_d = sticky_q;
`endif

    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          dv_d = bus.d;
          if (bus.d == '0) begin
            state_d  = StDone;
            dz_d     = 1'b1;
            ovf_d    = 1'b0;
            q_d      = '1;
            r_d      = bus.n[W-1:0];
`ifdef CSDIV_STICKY_EN
            sticky_d = |bus.n;
`endif
          end else if (bus.n[2*W-1:W] >= bus.d) begin
            state_d  = StDone;
            dz_d     = 1'b0;
            ovf_d    = 1'b1;
            q_d      = '1;
            r_d      = '0;
`ifdef CSDIV_STICKY_EN
            sticky_d = 1'b1;
`endif
          end else begin
            state_d = StRun;
            rem_d   = bus.n[2*W-1:W];
            lo_d    = bus.n[W-1:0];
            qreg_d  = '0;
            cnt_d   = '0;
          end
        end
      end
      StRun: begin
        rem_d  = rem_next;
        lo_d   = {lo_q[W-2:0], 1'b0};
        qreg_d = qreg_next;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(W - 1)) begin
          state_d  = StDone;
          q_d      = qreg_next;
          r_d      = rem_next;
          dz_d     = 1'b0;
          ovf_d    = 1'b0;
`ifdef CSDIV_STICKY_EN
          sticky_d = |rem_next;
`endif
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      rem_q    <= '0;
      lo_q     <= '0;
      dv_q     <= '0;
      qreg_q   <= '0;
      q_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef CSDIV_STICKY_EN
      sticky_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      lo_q     <= lo_d;
      dv_q     <= dv_d;
      qreg_q   <= qreg_d;
      q_q      <= q_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
`ifdef CSDIV_STICKY_EN
      sticky_q <= sticky_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.q         = q_q;
  assign bus.r         = r_q;
  assign bus.dz        = dz_q;
  assign bus.ovf       = ovf_q;
`ifdef CSDIV_STICKY_EN
  assign bus.sticky    = sticky_q;
`endif

endmodule
